// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the reg_file writeback initiator.
// The bypass feature (WB_BYPASS_EN) uses these same definitions.
package reg_writeback_pkg;

  localparam int REG_ADDR_W = 6;
  localparam logic [REG_ADDR_W-1:0] HI_ADDR = 6'd32;
  localparam logic [REG_ADDR_W-1:0] LO_ADDR = 6'd33;
  localparam int NUM_REGS = 34;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [31:0]           data;
    logic [31:0]           data_hi;
    logic                  pair;
  } wb_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LO
  } wb_state_t;

  // Register 0 is hard-wired and addresses past LO do not exist.
  function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] a);
    return (a != '0) && (a < REG_ADDR_W'(NUM_REGS));
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular request queue for reg_writeback; exposes its contents in
// age order (index 0 = head) so the top can search pending writes.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output wb_entry_t                  age_entry [DEPTH],
  output logic [DEPTH-1:0]           age_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic          rd_en;
  logic [PW:0]   age_idx;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign head   = mem[rd_ptr];
  assign wr_en  = push && !full;
  assign rd_en  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (rd_en) rd_ptr <= bump(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    age_idx   = '0;
    age_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = {1'b0, rd_ptr} + (PW+1)'(k);
      if (age_idx >= (PW+1)'(DEPTH)) age_idx = age_idx - (PW+1)'(DEPTH);
      age_entry[k] = mem[age_idx[PW-1:0]];
      age_valid[k] = (CW'(k) < cnt);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback initiator: queues register writes and drives the reg_file
// A3/WD3/WEN port, splitting HI/LO pairs. Optional bypass: WB_BYPASS_EN.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic                  req_pair,
  input  logic [31:0]           req_data_hi,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [31:0]           WD3,
  output logic                  WEN,
  output logic                  busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_addr,
  output logic                  byp_hit,
  output logic [31:0]           byp_data
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] a3_d;
  logic [31:0]           wd3_d;
  logic                  wen_d;
  logic [31:0]           lo_q, lo_d;
  logic                  push, pop, full, empty;
  logic [CW-1:0]         count;
  wb_entry_t             push_entry, head;
  wb_entry_t             age_entry [DEPTH];
  logic [DEPTH-1:0]      age_valid;

  assign req_ready  = !full;
  assign push       = req_valid && req_ready;
  assign push_entry = '{addr: req_addr, data: req_data, data_hi: req_data_hi, pair: req_pair};
  assign busy       = (count != '0) || (state_q == S_LO) || WEN;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      A3      <= '0;
      WD3     <= '0;
      WEN     <= 1'b0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      A3      <= a3_d;
      WD3     <= wd3_d;
      WEN     <= wen_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a3_d    = A3;
    wd3_d   = WD3;
    wen_d   = WEN;
    lo_d    = lo_q;
    pop     = 1'b0;
    case (state_q)
      S_LO: begin
        a3_d    = LO_ADDR;
        wd3_d   = lo_q;
        wen_d   = 1'b1;
        state_d = S_ISSUE;
      end
      default: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.pair) begin
            a3_d    = HI_ADDR;
            wd3_d   = head.data_hi;
            wen_d   = 1'b1;
            lo_d    = head.data;
            state_d = S_LO;
          end else begin
            // Unwritable targets still consume a slot, just with WEN low.
            a3_d    = head.addr;
            wd3_d   = head.data;
            wen_d   = addr_writable(head.addr);
            state_d = S_ISSUE;
          end
        end else begin
          wen_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

`ifdef WB_BYPASS_EN
  // Searched oldest to youngest so the last hit is the newest value.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_addr != '0) begin
      if (WEN && (A3 == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = WD3;
      end
      if ((state_q == S_LO) && (byp_addr == LO_ADDR)) begin
        byp_hit  = 1'b1;
        byp_data = lo_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (age_valid[k]) begin
          if (age_entry[k].pair) begin
            if (byp_addr == HI_ADDR) begin
              byp_hit  = 1'b1;
              byp_data = age_entry[k].data_hi;
            end else if (byp_addr == LO_ADDR) begin
              byp_hit  = 1'b1;
              byp_data = age_entry[k].data;
            end
          end else if (addr_writable(age_entry[k].addr) && (age_entry[k].addr == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = age_entry[k].data;
          end
        end
      end
    end
  end
`else
  logic unused_age;
  always_comb begin
    unused_age = ^age_valid;
    for (int k = 0; k < DEPTH; k++) unused_age = unused_age ^ (^age_entry[k]);
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized + directed bench for reg_writeback against a queue-level
// reference model and an in-order write scoreboard.
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_addr;
  logic [31:0] req_data;
  logic        req_pair;
  logic [31:0] req_data_hi;
  logic [5:0]  A3;
  logic [31:0] WD3;
  logic        WEN;
  logic        busy;
`ifdef WB_BYPASS_EN
  logic [5:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_pair    (req_pair),
    .req_data_hi (req_data_hi),
    .A3          (A3),
    .WD3         (WD3),
    .WEN         (WEN),
    .busy        (busy)
`ifdef WB_BYPASS_EN
    ,
    .byp_addr    (byp_addr),
    .byp_hit     (byp_hit),
    .byp_data    (byp_data)
`endif
  );

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] hi;
    logic        pair;
  } req_t;

  typedef struct {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference model: accepted-but-unissued requests, pending LO half,
  // and the value the write port should be showing.
  req_t        mq[$];
  bit          m_lo_pend;
  logic [31:0] m_lo;
  bit          m_wen;
  logic [5:0]  m_a3;
  logic [31:0] m_wd3;
  wr_t         sb[$];

  int errors = 0;
  int checks = 0;
  bit last_acc;
  bit stall_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit writable(input logic [5:0] a);
    return (a != 0) && (a < 34);
  endfunction

  function automatic req_t mk(input logic [5:0] a, input logic [31:0] d,
                              input logic p, input logic [31:0] h);
    req_t r;
    r.addr = a; r.data = d; r.pair = p; r.hi = h;
    return r;
  endfunction

  task automatic model_edge(input bit acc, input req_t r);
    req_t h;
    if (m_lo_pend) begin
      m_wen = 1; m_a3 = 6'd33; m_wd3 = m_lo; m_lo_pend = 0;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.pair) begin
        m_wen = 1; m_a3 = 6'd32; m_wd3 = h.hi; m_lo = h.data; m_lo_pend = 1;
      end else begin
        m_wen = writable(h.addr); m_a3 = h.addr; m_wd3 = h.data;
      end
    end else begin
      m_wen = 0;
    end
    if (acc) begin
      mq.push_back(r);
      if (r.pair) begin
        sb.push_back('{6'd32, r.hi});
        sb.push_back('{6'd33, r.data});
      end else if (writable(r.addr)) begin
        sb.push_back('{r.addr, r.data});
      end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic byp_model(input logic [5:0] b, output bit hit, output logic [31:0] d);
    hit = 0; d = 0;
    if (b == 0) return;
    if (m_wen && m_a3 == b) begin hit = 1; d = m_wd3; end
    if (m_lo_pend && b == 6'd33) begin hit = 1; d = m_lo; end
    foreach (mq[i]) begin
      if (mq[i].pair) begin
        if (b == 6'd32) begin hit = 1; d = mq[i].hi; end
        if (b == 6'd33) begin hit = 1; d = mq[i].data; end
      end else if (writable(mq[i].addr) && mq[i].addr == b) begin
        hit = 1; d = mq[i].data;
      end
    end
  endtask
`endif

  task automatic step(input bit v, input req_t r, input logic [5:0] baddr);
    bit acc;
    wr_t e;
`ifdef WB_BYPASS_EN
    bit          bh;
    logic [31:0] bd;
`endif
    acc = v && (mq.size() < DEPTH);
    if (v && !acc) stall_seen = 1;
    req_valid = v; req_addr = r.addr; req_data = r.data;
    req_pair = r.pair; req_data_hi = r.hi;
    @(posedge clk);
    model_edge(acc, r);
    #1;
    last_acc = acc;
    check_val("req_ready", req_ready, mq.size() < DEPTH);
    check_val("WEN", WEN, m_wen);
    if (m_wen) begin
      check_val("A3", A3, m_a3);
      check_val("WD3", WD3, m_wd3);
    end
    check_val("busy", busy, (mq.size() != 0) || m_lo_pend || m_wen);
    if (WEN === 1'b1) begin
      e = (sb.size() > 0) ? sb.pop_front() : '{6'h3f, 32'h0};
      check_val("sb_addr", A3, e.a);
      check_val("sb_data", WD3, e.d);
    end
`ifdef WB_BYPASS_EN
    byp_addr = baddr;
    #1;
    byp_model(baddr, bh, bd);
    check_val("byp_hit", byp_hit, bh);
    if (bh) check_val("byp_data", byp_data, bd);
`else
    if (baddr == 6'h3f) #0;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, mk(0, 0, 0, 0), 6'($urandom_range(0, 40)));
  endtask

  task automatic send(input req_t r);
    int n = 0;
    do begin
      step(1, r, 6'($urandom_range(0, 40)));
      n++;
    end while (!last_acc && n < 20);
    check_val("send_accept", last_acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || m_lo_pend || m_wen) && n < 60) begin
      idle(1);
      n++;
    end
    check_val("drain_sb_empty", sb.size(), 0);
    check_val("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    mq.delete(); sb.delete();
    m_lo_pend = 0; m_wen = 0; m_a3 = 0; m_wd3 = 0; m_lo = 0;
    check_val("rst_WEN", WEN, 0);
    check_val("rst_A3", A3, 0);
    check_val("rst_WD3", WD3, 0);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_busy", busy, 0);
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_addr = 0; req_data = 0; req_pair = 0; req_data_hi = 0;
`ifdef WB_BYPASS_EN
    byp_addr = 0;
`endif
    stall_seen = 0;
    do_reset();
    idle(1);

    // single write
    send(mk(5, 32'hDEADBEEF, 0, 0));
    idle(1);
    check_val("single_wen", WEN, 1);
    check_val("single_a3", A3, 5);
    check_val("single_wd3", WD3, 32'hDEADBEEF);
    idle(1);
    check_val("single_wen_off", WEN, 0);

    // pair followed by a normal write
    send(mk(0, 32'h2, 1, 32'h1));
    send(mk(9, 32'h99, 0, 0));
    check_val("pair_hi_a3", A3, 32);
    check_val("pair_hi_wd3", WD3, 1);
    idle(1);
    check_val("pair_lo_a3", A3, 33);
    check_val("pair_lo_wd3", WD3, 2);
    idle(1);
    check_val("pair_next_a3", A3, 9);
    drain();

    // backpressure
    stall_seen = 0;
    send(mk(0, 32'h201, 1, 32'h101));
    send(mk(0, 32'h202, 1, 32'h102));
    send(mk(12, 32'h103, 0, 0));
    send(mk(13, 32'h104, 0, 0));
    check_val("bp_stall_seen", stall_seen, 1);
    drain();

    // dropped addresses
    send(mk(0, 32'h11, 0, 0));
    check_val("drop_wen_a", WEN, 0);
    send(mk(40, 32'h22, 0, 0));
    check_val("drop_wen_b", WEN, 0);
    send(mk(3, 32'h33, 0, 0));
    check_val("drop_wen_c", WEN, 0);
    idle(1);
    check_val("drop_then_a3", A3, 3);
    check_val("drop_then_wen", WEN, 1);
    drain();

    // reset in the middle of a pair
    send(mk(0, 32'h66, 1, 32'h55));
    idle(1);
    check_val("midpair_hi", A3, 32);
    do_reset();
    idle(1);
    check_val("midpair_no_lo", WEN, 0);
    check_val("midpair_busy", busy, 0);

`ifdef WB_BYPASS_EN
    send(mk(7, 32'hA, 0, 0));
    send(mk(7, 32'hB, 0, 0));
    byp_addr = 7; #1;
    check_val("byp7_hit", byp_hit, 1);
    check_val("byp7_data", byp_data, 32'hB);
    byp_addr = 0; #1;
    check_val("byp0_hit", byp_hit, 0);
    drain();
`endif

    // random traffic with one reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step($urandom_range(0, 9) < 6,
           mk(6'($urandom_range(0, 40)), $urandom, $urandom_range(0, 4) == 0, $urandom),
           6'($urandom_range(0, 40)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL be the write-side initiator for the reg_file write port, driving A3/WD3/WEN from a queue of writeback requests.
REQ-002 Parameter DEPTH, default 2, SHALL set the request queue entries (2..8).
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at posedge.
REQ-008 req_addr  input  6  destination register, 0..33 (32=HI, 33=LO).
REQ-009 req_data  input  32  write data (LO data for pair requests).
REQ-010 req_pair  input  1  HI/LO pair write; req_addr ignored.
REQ-011 req_data_hi  input  32  HI data for pair requests.
REQ-012 A3  output  6  reg_file write address.
REQ-013 WD3  output  32  reg_file write data.
REQ-014 WEN  output  1  reg_file write enable.
REQ-015 busy  output  1  queue, LO stash or current write non-idle.

Function
REQ-016 req_ready SHALL be 1 iff queue count < DEPTH, computed from registered state only.
REQ-017 Push and pop on the same edge SHALL both occur; count unchanged.
REQ-018 Drain FSM states SHALL be S_IDLE, S_ISSUE, S_LO.
REQ-019 In S_IDLE/S_ISSUE with queue non-empty, each posedge SHALL pop the head and register it onto A3/WD3/WEN; next state S_LO if pair, else S_ISSUE.
REQ-020 In S_IDLE/S_ISSUE with queue empty, next posedge SHALL set WEN=0 and state S_IDLE; A3/WD3 hold.
REQ-021 Pair pop SHALL drive A3=32, WD3=req_data_hi, WEN=1, and stash LO data.
REQ-022 In S_LO the next posedge SHALL drive A3=33, WD3=stashed LO, WEN=1, then return to S_ISSUE; no pop occurs in that cycle.
REQ-023 Latency: request accepted at edge N SHALL appear on WEN=1 after edge N+1 when queue was empty and state not S_LO.
REQ-024 Non-pair requests with addr 0 or addr >= 34 SHALL be popped with WEN=0 (dropped, one cycle consumed).
REQ-025 Writes SHALL issue in acceptance order; queue pointers SHALL wrap modulo DEPTH.
REQ-026 busy SHALL be (count != 0) || state==S_LO || WEN.

Reset
REQ-027 Reset SHALL force WEN=0, A3=0, WD3=0, count=0, pointers=0, state S_IDLE, req_ready=1, busy=0.
REQ-028 Reset mid-pair SHALL discard the pending LO write; no write SHALL issue in the first cycle after deassertion.

Configuration
REQ-029 With WB_BYPASS_EN defined, ports byp_addr (input 6), byp_hit (output 1) and byp_data (output 32) SHALL exist.
REQ-030 byp_hit SHALL be combinational: 1 if byp_addr != 0 matches any pending write (queue entry, stashed LO, or current WEN=1 output); byp_data SHALL return the youngest match.
REQ-031 Without WB_BYPASS_EN the bypass ports and logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package reg_writeback_pkg SHALL hold REG_ADDR_W=6, HI_ADDR=32, LO_ADDR=33, NUM_REGS=34, the queue entry struct (addr, data, data_hi, pair) and the drain state enum.
REQ-033 The queue SHALL be sub-module wb_fifo (parameter DEPTH, push/pop/full/empty/count, head and per-entry visibility for bypass).

Verification
REQ-034 Single write: push addr 5, data 0xDEADBEEF at edge 0 -> A3=5, WD3=0xDEADBEEF, WEN=1 after edge 1; WEN=0 after edge 2.
REQ-035 Pair: push pair, hi=0x1, lo=0x2 -> consecutive cycles A3=32/WD3=1, then A3=33/WD3=2; a second request pushed meanwhile issues the cycle after.
REQ-036 Backpressure: push 4 requests back-to-back into DEPTH=2 -> req_ready drops to 0, all 4 writes issue in order, none lost or duplicated.
REQ-037 Drops: push addr 0 then addr 40 then addr 3 -> two cycles WEN=0, then WEN=1 with A3=3.
REQ-038 Reset mid-pair: assert reset after HI write -> no LO write, outputs at reset values, busy=0.
REQ-039 WB_BYPASS_EN: queue addr 7 twice (0xA then 0xB), byp_addr=7 -> byp_hit=1, byp_data=0xB; byp_addr=0 -> byp_hit=0.
